// File: rtl/av_pkg.sv
// Shared types, multiplier latencies and fixed-point helpers for the streaming A*V block.
// Build option: AV_ROUND_NEAREST_EN selects round-half-up in the Q2.30 -> Q1.15 conversion.
package av_pkg;

  typedef enum logic [1:0] {
    PREC_INT4 = 2'b00,
    PREC_INT8 = 2'b01,
    PREC_FP16 = 2'b10,
    PREC_RSVD = 2'b11
  } prec_t;

  localparam int unsigned LAT_INT4 = 1;
  localparam int unsigned LAT_INT8 = 2;
  localparam int unsigned LAT_FP16 = 4;

  // Reserved precision contributes nothing, so it takes the shortest path.
  function automatic logic [2:0] lat_of(prec_t p);
    case (p)
      PREC_INT8: return 3'(LAT_INT8);
      PREC_FP16: return 3'(LAT_FP16);
      default:   return 3'(LAT_INT4);
    endcase
  endfunction

  function automatic logic signed [15:0] sel_operand(logic [15:0] w, prec_t p);
    case (p)
      PREC_INT4: return {{12{w[15]}}, w[15:12]};
      PREC_INT8: return {{8{w[15]}}, w[15:8]};
      default:   return w;
    endcase
  endfunction

  function automatic logic [31:0] sat_add32(logic [31:0] a, logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31])
      return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return s[31:0];
  endfunction

  function automatic logic [15:0] q230_to_q115(logic [31:0] x);
    logic [32:0] y;
`ifdef AV_ROUND_NEAREST_EN
    y = {x[31], x} + 33'h0_0000_4000;
`else
    y = {x[31], x};
`endif
    if ((y[32] != y[31]) || (y[31] != y[30]))
      return y[32] ? 16'h8000 : 16'h7FFF;
    return {y[31], y[29:15]};
  endfunction

endpackage

// File: rtl/av_matmul_stream_if.sv
// Token input stream and output row stream of av_matmul_stream.
interface av_matmul_stream_if #(
  parameter int unsigned A_ROWS = 16,
  parameter int unsigned V_COLS = 32,
  parameter int unsigned DATA_W = 16
);
  logic                       tok_valid;
  logic                       tok_ready;
  logic [1:0]                 tok_prec;
  logic [A_ROWS*DATA_W-1:0]   tok_a;
  logic [V_COLS*DATA_W-1:0]   tok_v;
  logic                       out_valid;
  logic                       out_ready;
  logic [$clog2(A_ROWS)-1:0]  out_row;
  logic [V_COLS*DATA_W-1:0]   out_data;
  logic                       out_last;

  modport master (
    output tok_valid, tok_prec, tok_a, tok_v, out_ready,
    input  tok_ready, out_valid, out_row, out_data, out_last
  );

  modport slave (
    input  tok_valid, tok_prec, tok_a, tok_v, out_ready,
    output tok_ready, out_valid, out_row, out_data, out_last
  );
endinterface

// File: rtl/av_lane_mul.sv
// One signed 16x16 multiplier lane; product is aligned to Q2.30 and valid after the
// precision-dependent latency.
module av_lane_mul
  import av_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  prec_t              prec,
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic               valid_out,
  output logic [31:0]        prod
);

  logic [2:0]         cnt_q;
  logic [31:0]        prod_q;
  logic signed [31:0] raw;

  assign raw = 32'(a) * 32'(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (valid_in)
      cnt_q <= lat_of(prec);
    else if (cnt_q != '0)
      cnt_q <= cnt_q - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (valid_in) begin
      case (prec)
        PREC_INT4: prod_q <= raw <<< 24;
        PREC_INT8: prod_q <= raw <<< 16;
        PREC_FP16: prod_q <= raw;
        default:   prod_q <= '0;
      endcase
    end
  end

  assign valid_out = (cnt_q == 3'd1);
  assign prod      = prod_q;

endmodule

// File: rtl/av_matmul_stream.sv
// Streaming A*V multiply: accumulates per-token outer products in Q2.30 and drains Q1.15 rows.
// Build option AV_ROUND_NEAREST_EN (see av_pkg) changes output rounding.
module av_matmul_stream
  import av_pkg::*;
#(
  parameter int unsigned A_ROWS  = 16,
  parameter int unsigned NUM_TOK = 16,
  parameter int unsigned V_COLS  = 32,
  parameter int unsigned LANES   = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ACC_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                prec_err,
  av_matmul_stream_if.slave   bus
);

  localparam int unsigned GROUPS = V_COLS / LANES;
  localparam int unsigned R_W    = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
  localparam int unsigned G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned T_W    = $clog2(NUM_TOK + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOK_WAIT,
    S_ISSUE,
    S_WAIT_MUL,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [R_W-1:0]           r_q;
  logic [G_W-1:0]           g_q;
  logic [T_W-1:0]           tok_cnt_q;
  prec_t                    prec_q;
  logic [A_ROWS*DATA_W-1:0] a_q;
  logic [V_COLS*DATA_W-1:0] v_q;
  logic [ACC_W-1:0]         acc [A_ROWS][V_COLS];

  logic [DATA_W-1:0]        a_el [A_ROWS];
  logic signed [15:0]       a_op;
  logic [LANES-1:0]         lane_vld;
  logic [31:0]              lane_prod [LANES];

  logic start_acc, tok_acc, res_vld, out_hs, last_g, last_r, mul_valid;

  assign start_acc = (state_q == S_IDLE) && start;
  assign tok_acc   = (state_q == S_TOK_WAIT) && bus.tok_valid;
  assign res_vld   = (state_q == S_WAIT_MUL) && (&lane_vld);
  assign out_hs    = (state_q == S_DRAIN) && bus.out_ready;
  assign last_g    = (g_q == G_W'(GROUPS - 1));
  assign last_r    = (r_q == R_W'(A_ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      g_q       <= '0;
      tok_cnt_q <= '0;
      prec_q    <= PREC_INT4;
      prec_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        r_q       <= '0;
        g_q       <= '0;
        tok_cnt_q <= '0;
        prec_err  <= 1'b0;
      end
      if (tok_acc) begin
        prec_q <= prec_t'(bus.tok_prec);
        if (bus.tok_prec == 2'b11)
          prec_err <= 1'b1;
      end
      // r walks the accumulate rows, wrapping to 0 so DRAIN starts on row 0.
      if (res_vld) begin
        g_q <= last_g ? '0 : g_q + 1'b1;
        if (last_g) begin
          r_q <= last_r ? '0 : r_q + 1'b1;
          if (last_r)
            tok_cnt_q <= tok_cnt_q + 1'b1;
        end
      end
      if (out_hs)
        r_q <= last_r ? '0 : r_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tok_acc) begin
      a_q <= bus.tok_a;
      v_q <= bus.tok_v;
    end
  end

  always_comb begin
    state_d       = state_q;
    busy          = 1'b0;
    done          = 1'b0;
    mul_valid     = 1'b0;
    bus.tok_ready = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_row   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start)
          state_d = S_TOK_WAIT;
      end
      S_TOK_WAIT: begin
        busy          = 1'b1;
        bus.tok_ready = 1'b1;
        if (bus.tok_valid)
          state_d = S_ISSUE;
      end
      S_ISSUE: begin
        busy      = 1'b1;
        mul_valid = 1'b1;
        state_d   = S_WAIT_MUL;
      end
      S_WAIT_MUL: begin
        busy = 1'b1;
        if (res_vld) begin
          if (!(last_g && last_r))
            state_d = S_ISSUE;
          else if (tok_cnt_q == T_W'(NUM_TOK - 1))
            state_d = S_DRAIN;
          else
            state_d = S_TOK_WAIT;
        end
      end
      S_DRAIN: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_row   = r_q;
        bus.out_last  = last_r;
        if (bus.out_ready && last_r)
          state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar rr = 0; rr < A_ROWS; rr++) begin : g_a_el
    assign a_el[rr] = a_q[rr*DATA_W +: DATA_W];
  end

  assign a_op = sel_operand(a_el[r_q], prec_q);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DATA_W-1:0]  v_el [GROUPS];
    logic signed [15:0] v_op;

    for (genvar gg = 0; gg < GROUPS; gg++) begin : g_v_el
      assign v_el[gg] = v_q[(gg*LANES + l)*DATA_W +: DATA_W];
    end

    assign v_op = sel_operand(v_el[g_q], prec_q);

    av_lane_mul u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (mul_valid),
      .prec      (prec_q),
      .a         (a_op),
      .b         (v_op),
      .valid_out (lane_vld[l]),
      .prod      (lane_prod[l])
    );
  end

  // Accumulators carry no reset; they are cleared when a job is accepted.
  for (genvar rr = 0; rr < A_ROWS; rr++) begin : g_acc_r
    for (genvar cc = 0; cc < V_COLS; cc++) begin : g_acc_c
      always_ff @(posedge clk) begin
        if (start_acc)
          acc[rr][cc] <= '0;
        else if (res_vld && (r_q == R_W'(rr)) && (g_q == G_W'(cc / LANES)))
          acc[rr][cc] <= sat_add32(acc[rr][cc], lane_prod[cc % LANES]);
      end
    end
  end

  for (genvar cc = 0; cc < V_COLS; cc++) begin : g_out
    assign bus.out_data[cc*DATA_W +: DATA_W] =
      (state_q == S_DRAIN) ? q230_to_q115(acc[r_q][cc]) : '0;
  end

endmodule

// File: tb/tb_av_matmul_stream.sv
// Directed and randomized jobs for av_matmul_stream against an arithmetic reference model.
module tb_av_matmul_stream;

  localparam int unsigned A_ROWS  = 16;
  localparam int unsigned NUM_TOK = 16;
  localparam int unsigned V_COLS  = 32;
  localparam int unsigned LANES   = 8;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned VW      = V_COLS * 16;

`ifdef AV_ROUND_NEAREST_EN
  localparam logic [15:0] RND_EXP = 16'h0001;
`else
  localparam logic [15:0] RND_EXP = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, prec_err;

  int checks = 0;
  int failures = 0;

  av_matmul_stream_if #(.A_ROWS(A_ROWS), .V_COLS(V_COLS), .DATA_W(DATA_W)) ifc ();

  av_matmul_stream #(
    .A_ROWS(A_ROWS), .NUM_TOK(NUM_TOK), .V_COLS(V_COLS),
    .LANES(LANES), .DATA_W(DATA_W), .ACC_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .done(done), .prec_err(prec_err), .bus(ifc.slave)
  );

  always #5 clk = ~clk;

  logic [15:0]   ta [NUM_TOK][A_ROWS];
  logic [15:0]   tv [NUM_TOK][V_COLS];
  logic [1:0]    tp [NUM_TOK];
  logic [VW-1:0] exp_row [A_ROWS];
  logic          exp_err;

  task automatic check(string tag, logic [VW-1:0] obs, logic [VW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Real value of an element is opval * 2^-f (f = 3, 7, 15); product scaled to 2^-30.
  function automatic longint opval(logic [15:0] w, logic [1:0] p);
    case (p)
      2'b00:   return longint'($signed(w[15:12]));
      2'b01:   return longint'($signed(w[15:8]));
      default: return longint'($signed(w));
    endcase
  endfunction

  function automatic longint scale(logic [1:0] p);
    case (p)
      2'b00:   return longint'(1) << 24;
      2'b01:   return longint'(1) << 16;
      2'b10:   return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] to_q115(longint a);
    longint q;
`ifdef AV_ROUND_NEAREST_EN
    a = a + 16384;
`endif
    q = a >>> 15;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  task automatic build_model();
    longint acc [A_ROWS][V_COLS];
    longint s;
    exp_err = 1'b0;
    for (int r = 0; r < A_ROWS; r++)
      for (int c = 0; c < V_COLS; c++) acc[r][c] = 0;
    for (int t = 0; t < NUM_TOK; t++) begin
      if (tp[t] == 2'b11) exp_err = 1'b1;
      for (int r = 0; r < A_ROWS; r++)
        for (int c = 0; c < V_COLS; c++) begin
          s = acc[r][c] + opval(ta[t][r], tp[t]) * opval(tv[t][c], tp[t]) * scale(tp[t]);
          if (s > 64'sh7FFF_FFFF)  s = 64'sh7FFF_FFFF;
          if (s < -64'sh8000_0000) s = -64'sh8000_0000;
          acc[r][c] = s;
        end
    end
    for (int r = 0; r < A_ROWS; r++)
      for (int c = 0; c < V_COLS; c++) exp_row[r][c*16 +: 16] = to_q115(acc[r][c]);
  endtask

  task automatic fill_all(logic [1:0] p, logic [15:0] av, logic [15:0] vv);
    for (int t = 0; t < NUM_TOK; t++) begin
      tp[t] = p;
      for (int r = 0; r < A_ROWS; r++) ta[t][r] = av;
      for (int c = 0; c < V_COLS; c++) tv[t][c] = vv;
    end
  endtask

  task automatic set_tok(int t, logic [1:0] p, logic [15:0] av, logic [15:0] vv);
    tp[t] = p;
    for (int r = 0; r < A_ROWS; r++) ta[t][r] = av;
    for (int c = 0; c < V_COLS; c++) tv[t][c] = vv;
  endtask

  task automatic rand_tok(int t, logic [1:0] p);
    tp[t] = p;
    for (int r = 0; r < A_ROWS; r++) ta[t][r] = 16'($urandom);
    for (int c = 0; c < V_COLS; c++) tv[t][c] = 16'($urandom);
  endtask

  task automatic run_job(string name, bit bp, bit stall, bit kchk, logic [15:0] kval);
    int n, idx, stall_n, done_n;
    build_model();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check({name, "_busy"}, VW'(busy), VW'(1));
    @(posedge clk); #1;
    for (int t = 0; t < NUM_TOK; t++) begin
      for (int r = 0; r < A_ROWS; r++) ifc.tok_a[r*16 +: 16] = ta[t][r];
      for (int c = 0; c < V_COLS; c++) ifc.tok_v[c*16 +: 16] = tv[t][c];
      ifc.tok_prec  = tp[t];
      ifc.tok_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!ifc.tok_ready && n < 1000) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk); #1 ifc.tok_valid = 1'b0;
      if (n >= 1000) begin
        check({name, "_tok_timeout"}, VW'(0), VW'(1));
        return;
      end
    end
    ifc.out_ready = 1'b1;
    idx = 0; n = 0; stall_n = 0;
    while (idx < A_ROWS && n < 20000) begin
      @(negedge clk);
      n++;
      if (ifc.out_valid) begin
        check({name, "_row"}, VW'(ifc.out_row), VW'(idx));
        check({name, "_data"}, ifc.out_data, exp_row[idx]);
        check({name, "_last"}, VW'(ifc.out_last), VW'(idx == A_ROWS - 1));
        if (kchk) begin
          check({name, "_elem0"}, VW'(ifc.out_data[15:0]), VW'(kval));
          check({name, "_elemN"}, VW'(ifc.out_data[VW-1 -: 16]), VW'(kval));
        end
        if (stall && stall_n > 0 && stall_n <= 5)
          check({name, "_tok_ready_drain"}, VW'(ifc.tok_ready), VW'(0));
        if (ifc.out_ready) idx++;
      end
      @(posedge clk); #1;
      ifc.out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      ifc.tok_valid = 1'b0;
      start         = 1'b0;
      if (stall && idx == 3 && stall_n < 5) begin
        ifc.out_ready = 1'b0;
        ifc.tok_valid = 1'b1;
        start         = 1'b1;
        stall_n++;
      end
    end
    if (idx < A_ROWS) check({name, "_drain_timeout"}, VW'(idx), VW'(A_ROWS));
    done_n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) begin
        done_n++;
        check({name, "_busy_done"}, VW'(busy), VW'(0));
        check({name, "_prec_err"}, VW'(prec_err), VW'(exp_err));
        if (stall) start = 1'b1;
      end
      @(posedge clk); #1 start = 1'b0;
    end
    check({name, "_done_pulses"}, VW'(done_n), VW'(1));
    @(negedge clk);
    check({name, "_idle_after"}, VW'(busy), VW'(0));
  endtask

  initial begin
    ifc.tok_valid = 1'b0;
    ifc.tok_prec  = 2'b00;
    ifc.tok_a     = '0;
    ifc.tok_v     = '0;
    ifc.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",      VW'(busy),          VW'(0));
    check("rst_tok_ready", VW'(ifc.tok_ready), VW'(0));
    check("rst_out_valid", VW'(ifc.out_valid), VW'(0));
    check("rst_out_last",  VW'(ifc.out_last),  VW'(0));
    check("rst_done",      VW'(done),          VW'(0));
    check("rst_prec_err",  VW'(prec_err),      VW'(0));
    check("rst_out_row",   VW'(ifc.out_row),   VW'(0));
    check("rst_out_data",  ifc.out_data,       VW'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    fill_all(2'b01, 16'h0000, 16'h0000);
    set_tok(0, 2'b01, 16'h4000, 16'h4000);
    run_job("int8", 1'b0, 1'b1, 1'b1, 16'h2000);

    fill_all(2'b00, 16'h0000, 16'h0000);
    set_tok(0, 2'b00, 16'h4FFF, 16'h2000);
    run_job("int4", 1'b1, 1'b0, 1'b1, 16'h1000);

    fill_all(2'b10, 16'h0000, 16'h0000);
    set_tok(0, 2'b10, 16'h8000, 16'h8000);
    run_job("fp16_neg1sq", 1'b0, 1'b0, 1'b1, 16'h7FFF);

    set_tok(0, 2'b10, 16'h8000, 16'h7FFF);
    run_job("fp16_negmax", 1'b0, 1'b0, 1'b1, 16'h8001);

    fill_all(2'b10, 16'h7FFF, 16'h7FFF);
    run_job("fp16_sat", 1'b1, 1'b0, 1'b1, 16'h7FFF);

    fill_all(2'b10, 16'h0000, 16'h0000);
    rand_tok(5, 2'b11);
    run_job("rsvd", 1'b0, 1'b0, 1'b1, 16'h0000);

    fill_all(2'b10, 16'h0000, 16'h0000);
    set_tok(0, 2'b10, 16'h4000, 16'h0001);
    run_job("round", 1'b0, 1'b0, 1'b1, RND_EXP);

    repeat (3) begin
      for (int t = 0; t < NUM_TOK; t++) rand_tok(t, 2'($urandom_range(0, 3)));
      run_job("rand", 1'b1, 1'b0, 1'b0, 16'h0000);
    end

    // Abort a job part-way through with an asynchronous reset.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ifc.tok_prec  = 2'b11;
    ifc.tok_valid = 1'b1;
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy",      VW'(busy),          VW'(0));
    check("midrst_tok_ready", VW'(ifc.tok_ready), VW'(0));
    check("midrst_out_valid", VW'(ifc.out_valid), VW'(0));
    check("midrst_prec_err",  VW'(prec_err),      VW'(0));
    ifc.tok_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    for (int t = 0; t < NUM_TOK; t++) rand_tok(t, 2'b00);
    run_job("post_rst", 1'b1, 1'b0, 1'b0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
